// File: rtl/spi_txn_arbiter.sv
// SPI transaction arbiter: picks between a write and a read requester,
// issues one command to the SPI engine, waits for completion or timeout,
// then enforces an idle gap before the next command.
module spi_txn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic       Mclk,
  input  logic       nReset,
  input  logic       req_wr,
  input  logic [6:0] wr_addr,
  input  logic       req_rd,
  input  logic [6:0] rd_addr,
  input  logic       rx_afull,
  input  logic       spi_done,
  output logic       grant_wr,
  output logic       grant_rd,
  output logic       spi_start,
  output logic       spi_rnw,
  output logic [6:0] spi_addr,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Last wait-counter value before the transaction is abandoned.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  // Last gap-counter value; unused when the gap is disabled.
  localparam logic [3:0]  GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  // State entered when a transaction finishes (done or timeout).
  localparam state_t      POST_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t      state_r, state_s;
  logic [15:0] wait_cnt_r, wait_cnt_s;
  logic [3:0]  gap_cnt_r, gap_cnt_s;
  logic        last_rd_r, last_rd_s;
  logic        armed_r;
  logic        wr_elig_s, rd_elig_s, pick_rd_s;
  logic        spi_start_s, grant_wr_s, grant_rd_s, spi_rnw_s, timeout_err_s;
  logic [6:0]  spi_addr_s;
  logic [7:0]  err_count_s;

  // Next-state, arbitration and next-output computation.
  always_comb begin
    state_s       = state_r;
    wait_cnt_s    = wait_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    last_rd_s     = last_rd_r;
    spi_start_s   = 1'b0;
    grant_wr_s    = 1'b0;
    grant_rd_s    = 1'b0;
    spi_rnw_s     = spi_rnw;
    spi_addr_s    = spi_addr;
    timeout_err_s = 1'b0;
    err_count_s   = err_count;

    wr_elig_s = req_wr;
    rd_elig_s = req_rd & ~rx_afull;
    // Read wins only if it is alone, or on a tie when write went last.
    pick_rd_s = rd_elig_s & (~wr_elig_s | ~last_rd_r);

    case (state_r)
      IDLE: begin
        if (armed_r && (wr_elig_s || rd_elig_s)) begin
          state_s     = START;
          spi_start_s = 1'b1;
          grant_rd_s  = pick_rd_s;
          grant_wr_s  = ~pick_rd_s;
          spi_rnw_s   = pick_rd_s;
          spi_addr_s  = pick_rd_s ? rd_addr : wr_addr;
          last_rd_s   = pick_rd_s;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s    = WAIT_DONE;
        wait_cnt_s = 16'd0;
      end
      WAIT_DONE: begin
        if (spi_done) begin
          // Completion takes priority over a coincident timeout.
          state_s   = POST_WAIT;
          gap_cnt_s = 4'd0;
        end else if (wait_cnt_r == TO_LAST) begin
          state_s       = POST_WAIT;
          gap_cnt_s     = 4'd0;
          timeout_err_s = 1'b1;
          err_count_s   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        end else begin
          wait_cnt_s = wait_cnt_r + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 16'd0;
      gap_cnt_r   <= 4'd0;
      last_rd_r   <= 1'b1;
      armed_r     <= 1'b0;
      spi_start   <= 1'b0;
      grant_wr    <= 1'b0;
      grant_rd    <= 1'b0;
      spi_rnw     <= 1'b0;
      spi_addr    <= 7'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      last_rd_r   <= last_rd_s;
      // Holds off arbitration for the first edge after reset release.
      armed_r     <= 1'b1;
      spi_start   <= spi_start_s;
      grant_wr    <= grant_wr_s;
      grant_rd    <= grant_rd_s;
      spi_rnw     <= spi_rnw_s;
      spi_addr    <= spi_addr_s;
      busy        <= (state_s != IDLE);
      timeout_err <= timeout_err_s;
      err_count   <= err_count_s;
    end
  end

endmodule
